fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 63 ++++++
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch-queue entry layout, the fetch FSM state encoding and PC alignment.
package fetch_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_entry_t;

    // Drops the byte-offset bits so every fetch address is instruction aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// FIFO of fetched instructions between the fetch FSM and decode.
// Flush wins over push/pop; the head reads as zero whenever the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    fetch_entry_t  r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - CW'(1);
        end
    end

    // Storage carries no reset; reads are masked by the empty flag instead.
    always_ff @(posedge clk) begin
        if (rst_n && w_do_push && !i_flush)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && w_full));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, branch-prediction steering, single-outstanding
// memory request FSM and a queue of fetched instructions toward decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [31:0]  pred_pc,
    input  logic         pred_valid,
    input  logic         pred_taken,
    input  logic [31:0]  pred_target,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_resp_valid,
    input  logic [31:0]  imem_resp_data,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         if_valid,
    input  logic         if_ready,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_instr,
    output logic         if_pred_taken,
    output logic [31:0]  if_pred_target,
    output fetch_state_t dbg_state
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_lat_pc;
    logic         r_lat_taken;
    logic [31:0]  r_lat_target;

    fetch_state_t w_state_nxt;
    logic [31:0]  w_pc_nxt;
    logic         w_pred_hit;
    logic         w_req_valid;
    logic         w_req_fire;
    logic         w_push;
    logic         w_pop;
    logic         w_fq_valid;
    logic         w_fq_full;
    logic [CNT_W-1:0] w_fq_count;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    // Handshakes (imem request, decode): a transfer occurs on a cycle where valid
    // and ready are both high; valid never depends on the matching ready.
    assign w_pred_hit  = pred_valid && pred_taken;
    assign w_fq_valid  = (w_fq_count != '0);
    assign w_fq_full   = (w_fq_count == CNT_W'(FQ_DEPTH));
    assign w_req_valid = rst_n && (r_state == ST_ISSUE) && !redirect_valid && !w_fq_full;
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_push      = (r_state == ST_WAIT) && imem_resp_valid && !redirect_valid;
    assign w_pop       = rst_n && w_fq_valid && if_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_ISSUE: if (w_req_fire) w_state_nxt = ST_WAIT;
            // A response always closes the outstanding request, even if a redirect drops it.
            ST_WAIT: begin
                if (imem_resp_valid)     w_state_nxt = ST_ISSUE;
                else if (redirect_valid) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: if (imem_resp_valid) w_state_nxt = ST_ISSUE;
            default:  w_state_nxt = ST_ISSUE;
        endcase
        if (redirect_valid)
            w_pc_nxt = align_pc(redirect_pc);
        else if (w_req_fire)
            w_pc_nxt = w_pred_hit ? align_pc(pred_target) : r_pc + INSTR_BYTES;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_ISSUE;
            r_pc         <= RESET_PC;
            r_lat_pc     <= '0;
            r_lat_taken  <= 1'b0;
            r_lat_target <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_req_fire) begin
                r_lat_pc     <= r_pc;
                r_lat_taken  <= w_pred_hit;
                r_lat_target <= pred_target;
            end
        end
    end

    always_comb begin
        w_push_entry.pc          = r_lat_pc;
        w_push_entry.instr       = imem_resp_data;
        w_push_entry.pred_taken  = r_lat_taken;
        w_push_entry.pred_target = r_lat_target;
    end

    fetch_queue #(
        .DEPTH(FQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_data(w_push_entry),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_head     (w_head),
        .o_count    (w_fq_count)
    );

    assign pred_pc        = r_pc;
    assign imem_req_addr  = r_pc;
    assign imem_req_valid = w_req_valid;
    assign if_valid       = rst_n && w_fq_valid;
    assign if_pc          = rst_n ? w_head.pc : '0;
    assign if_instr       = rst_n ? w_head.instr : '0;
    assign if_pred_taken  = rst_n && w_head.pred_taken;
    assign if_pred_target = rst_n ? w_head.pred_target : '0;
    assign dbg_state      = r_state;

    a_no_resp_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_resp_valid && (r_state == ST_ISSUE)));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: transaction-level reference model with a
// memory responder, directed scenarios with literal expectations, then random traffic.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  pred_pc;
    logic         pred_valid, pred_taken;
    logic [31:0]  pred_target;
    logic         imem_req_valid, imem_req_ready;
    logic [31:0]  imem_req_addr;
    logic         imem_resp_valid;
    logic [31:0]  imem_resp_data;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         if_valid, if_ready;
    logic [31:0]  if_pc, if_instr;
    logic         if_pred_taken;
    logic [31:0]  if_pred_target;
    fetch_state_t dbg_state;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_pc(pred_pc), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_target(pred_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] tgt;
    } ent_t;

    // Reference model: expected queue contents, fetch PC, outstanding/stale request.
    ent_t        exp_q[$];
    logic [31:0] m_pc;
    bit          m_out, m_stale, m_known;
    ent_t        m_lat;

    // Memory responder: one outstanding request, answered mem_cnt cycles later.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_data;
    int          mem_lat_cfg;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit rd, input logic [31:0] rd_pc, input bit rdy,
                        input bit pv, input bit pt, input logic [31:0] ptgt, input bit req_rdy);
        bit   exp_rv, resp, fire, pop, push;
        ent_t e;
        @(negedge clk);
        rst_n          = !rst;
        redirect_valid = rd;
        redirect_pc    = rd_pc;
        if_ready       = rdy;
        pred_valid     = pv;
        pred_taken     = pt;
        pred_target    = ptgt;
        imem_req_ready = req_rdy;
        resp = !rst && mem_busy && (mem_cnt == 1);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_data : $urandom;
        #1;
        exp_rv = !rst && !m_out && !rd && (exp_q.size() < FQ_DEPTH);
        if (m_known) begin
            chk("pred_pc", pred_pc, m_pc);
            chk("req_addr", imem_req_addr, m_pc);
            chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            chk("if_valid", 32'(if_valid), 32'(!rst && exp_q.size() != 0));
            if (rst) begin
                chk("rst_if_pc", if_pc, 32'h0);
                chk("rst_if_instr", if_instr, 32'h0);
                chk("rst_if_taken", 32'(if_pred_taken), 32'h0);
                chk("rst_if_target", if_pred_target, 32'h0);
            end else if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("if_pc", if_pc, e.pc);
                chk("if_instr", if_instr, e.instr);
                chk("if_pred_taken", 32'(if_pred_taken), 32'(e.taken));
                chk("if_pred_target", if_pred_target, e.tgt);
            end
        end
        fire = exp_rv && req_rdy;
        if (rst) begin
            m_pc = RESET_PC; m_out = 0; m_stale = 0; exp_q.delete();
            m_lat = '{32'd0, 32'd0, 1'b0, 32'd0};
            mem_busy = 0; m_known = 1;
        end else begin
            pop  = (exp_q.size() != 0) && rdy && !rd;
            push = m_out && !m_stale && resp && !rd;
            if (rd) begin
                exp_q.delete();
                m_pc = rd_pc & 32'hFFFF_FFFC;
                if (m_out && !resp) m_stale = 1;
            end else begin
                if (pop)  void'(exp_q.pop_front());
                if (push) exp_q.push_back('{pc: m_lat.pc, instr: mem_data, taken: m_lat.taken, tgt: m_lat.tgt});
            end
            if (resp) begin
                m_out = 0; m_stale = 0; mem_busy = 0;
            end else if (mem_busy) begin
                mem_cnt--;
            end
            if (fire) begin
                m_lat = '{m_pc, 32'd0, pv && pt, ptgt};
                m_pc  = (pv && pt) ? (ptgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
                m_out = 1;
                mem_busy = 1;
                mem_cnt  = (mem_lat_cfg != 0) ? mem_lat_cfg : int'($urandom_range(1, 3));
                mem_data = $urandom;
            end
        end
    endtask

    task automatic run(input bit rd, input logic [31:0] rd_pc, input bit rdy,
                       input bit pv, input bit pt, input logic [31:0] ptgt);
        step(1'b0, rd, rd_pc, rdy, pv, pt, ptgt, 1'b1);
    endtask

    initial begin
        rst_n = 0; redirect_valid = 0; redirect_pc = 0; if_ready = 0;
        pred_valid = 0; pred_taken = 0; pred_target = 0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        m_known = 0; m_pc = RESET_PC; m_out = 0; m_stale = 0; mem_busy = 0; mem_cnt = 0;
        mem_data = 0; mem_lat_cfg = 1;
        m_lat = '{32'd0, 32'd0, 1'b0, 32'd0};

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Sequential fetch with a 1-cycle memory, then a taken prediction at 0x8.
        run(0, 0, 1, 0, 0, 0);  chk("seq_valid0", 32'(imem_req_valid), 32'h1);
                                chk("seq_addr0", imem_req_addr, 32'h0);
        run(0, 0, 1, 0, 0, 0);  chk("seq_wait", 32'(imem_req_valid), 32'h0);
        run(0, 0, 1, 0, 0, 0);  chk("seq_ifpc0", if_pc, 32'h0);
                                chk("seq_addr4", imem_req_addr, 32'h4);
        run(0, 0, 1, 0, 0, 0);
        run(0, 0, 1, 1, 1, 32'h100);
                                chk("seq_ifpc4", if_pc, 32'h4);
                                chk("seq_addr8", imem_req_addr, 32'h8);
        run(0, 0, 1, 0, 0, 0);
        run(0, 0, 1, 0, 0, 0);  chk("pred_addr", imem_req_addr, 32'h100);
                                chk("pred_ifpc", if_pc, 32'h8);
                                chk("pred_taken_q", 32'(if_pred_taken), 32'h1);
                                chk("pred_target_q", if_pred_target, 32'h100);

        // Decode stalled: queue fills to depth, then one pop lets one request out.
        for (int i = 0; i < 12; i++) run(0, 0, 0, 0, 0, 0);
        chk("full_noreq", 32'(imem_req_valid), 32'h0);
        chk("full_head", if_pc, 32'h100);
        run(0, 0, 1, 0, 0, 0);  chk("full_pop_noreq", 32'(imem_req_valid), 32'h0);
        run(0, 0, 0, 0, 0, 0);  chk("after_pop_req", 32'(imem_req_valid), 32'h1);
                                chk("after_pop_addr", imem_req_addr, 32'h110);
                                chk("after_pop_head", if_pc, 32'h104);
        run(0, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0);  chk("refull_noreq", 32'(imem_req_valid), 32'h0);

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Redirect while a slow response is outstanding.
        mem_lat_cfg = 3;
        run(0, 0, 1, 0, 0, 0);  chk("rst_ifvalid", 32'(if_valid), 32'h0);
                                chk("rst_pc", pred_pc, RESET_PC);
        run(1, 32'h200, 1, 0, 0, 0);  chk("rdw_noreq", 32'(imem_req_valid), 32'h0);
        run(0, 0, 1, 0, 0, 0);  chk("flush_noreq1", 32'(imem_req_valid), 32'h0);
        run(0, 0, 1, 0, 0, 0);  chk("flush_noreq2", 32'(imem_req_valid), 32'h0);
        run(0, 0, 1, 0, 0, 0);  chk("rd_req_valid", 32'(imem_req_valid), 32'h1);
                                chk("rd_req_addr", imem_req_addr, 32'h200);
        run(0, 0, 1, 0, 0, 0);
        run(0, 0, 1, 0, 0, 0);  chk("no_stale", 32'(if_valid), 32'h0);
        run(0, 0, 1, 0, 0, 0);
        mem_lat_cfg = 1;
        run(0, 0, 0, 0, 0, 0);  chk("rd_ifpc", if_pc, 32'h200);

        // Redirect in the same cycle as the response; back-to-back redirects; PC wrap.
        run(1, 32'h303, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0);  chk("same_empty", 32'(if_valid), 32'h0);
                                chk("same_req", 32'(imem_req_valid), 32'h1);
                                chk("same_addr", imem_req_addr, 32'h300);
        run(1, 32'h1234, 0, 0, 0, 0);
        run(1, 32'hFFFF_FFFE, 0, 0, 0, 0);
                                chk("b2b_pc1", pred_pc, 32'h1234);
        run(0, 0, 0, 0, 0, 0);  chk("b2b_addr", imem_req_addr, 32'hFFFF_FFFC);
        run(0, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0);  chk("wrap_addr", imem_req_addr, 32'h0);
                                chk("wrap_ifpc", if_pc, 32'hFFFF_FFFC);

        // Random traffic.
        mem_lat_cfg = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt & 32'h0000_0FFC;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 9) < 7,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt,
                 $urandom_range(0, 9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
